dma_req_sched: RTL and testbench
================================

# dma_req_sched

Request scheduler between the BAR0 DMA control registers and the TLP transmit engine. Latches one DMA-write job and one DMA-read job from their start pulses, address and byte-length fields. Splits each job into max-payload / max-read-request-sized chunks and arbitrates the two channels round-robin onto a single valid/ready request port. Reports per-channel busy status and a done pulse.

## Interface
- `MAX_PAYLOAD_BYTES`, 128: largest MWr chunk in bytes; multiple of 4, ≤ 4096.
- `MAX_READ_BYTES`, 512: largest MRd chunk in bytes; multiple of 4, ≤ 4096.
- `pcie_clk`  in  1  125 MHz clock; single clock domain.
- `pcie_rst`  in  1  reset; synchronous, active-high.
- `dma_wr_start`  in  1  one-cycle pulse; starts a write job.
- `dma_wr_addr`  in  32  write job host byte address.
- `dma_wr_len`  in  32  write job length in bytes.
- `dma_rd_start`  in  1  one-cycle pulse; starts a read job.
- `dma_rd_addr`  in  32  read job host byte address.
- `dma_rd_len`  in  32  read job length in bytes.
- `tlp_req_valid`  out  1  chunk request valid.
- `tlp_req_ready`  in  1  TLP engine accepts the request.
- `tlp_req_type`  out  1  0 = MWr chunk, 1 = MRd chunk.
- `tlp_req_addr`  out  32  chunk byte address; bits [1:0] = 0.
- `tlp_req_dw`  out  11  chunk length in DW, 1..1024.
- `dma_wr_busy`  out  1  write job in progress.
- `dma_rd_busy`  out  1  read job in progress.
- `dma_wr_done`  out  1  one-cycle pulse; last write chunk accepted.
- `dma_rd_done`  out  1  one-cycle pulse; last read chunk accepted.

## Operation
- Each channel keeps a current address `cur_addr` and a byte count `remaining`.
- Start pulse while the channel is idle:
  - latch `addr & ~3` and `len & ~3`;
  - set busy;
  - the low two bits of both inputs are discarded.
- Start pulse while the channel is busy: ignored. The latched job is unaffected.
- Start with a truncated length of 0: busy stays 0, no request is issued, done pulses on the next cycle.
- Chunk size in bytes: `min(remaining, MAX_x_BYTES, 4096 - cur_addr[11:0])`. The 4 KB term applies only with the macro enabled (see Configuration).
- Arbiter FSM:
  - `ARB`:
    - if any busy channel has `remaining` > 0, select one, register type/addr/dw and go to `ISSUE`;
    - with both channels eligible, grant the channel not granted last;
    - the last-grant pointer resets to "read", so write wins the first tie.
  - `ISSUE`: `tlp_req_valid` = 1, outputs held stable. On `valid & ready`:
    - `cur_addr += chunk`, `remaining -= chunk`, both 32-bit with no saturation;
    - if `remaining` becomes 0, clear busy and pulse done;
    - return to `ARB`.
- Address arithmetic wraps modulo 2^32 with no error. Software guarantees jobs do not wrap.

## Timing
- Reset values: every output = 0, FSM = `ARB`, both channels idle, `remaining` = 0.
- `pcie_rst` mid-operation:
  - all state and outputs clear on that edge; `tlp_req_valid` drops even if not yet accepted;
  - no done pulse is generated.
- Start pulse sampled at edge N: channel busy from N+1; `ARB` evaluates in cycle N+1; `tlp_req_valid` asserts from N+2 (2-cycle start-to-request latency when idle).
- After a handshake at edge M:
  - `tlp_req_valid` = 0 in cycle M+1 (`ARB`);
  - the next request is valid at M+2, so throughput is 1 chunk per 2 cycles;
  - done pulse and busy clear are visible in cycle M+1.
- While `tlp_req_valid` = 1 and `tlp_req_ready` = 0: type, addr and dw are held unchanged. Valid is never withdrawn except by reset.
- Start on the same cycle as the channel's final handshake: ignored, because the channel is still busy in that cycle.
- Zero-length done pulse: cycle N+1.

## Configuration
- `DMA_SCHED_4K_SPLIT_EN`:
  - defined: chunks never cross a 4 KB host address boundary (the third term of the chunk size is active);
  - undefined: chunk size = `min(remaining, MAX_x_BYTES)` and the boundary logic is removed.

## Test plan
- Write `addr=0x1000`, `len=256`, MPS 128 -> MWr `0x1000`/32 DW, then MWr `0x1080`/32 DW; `dma_wr_done` one cycle after the second handshake; `dma_wr_busy` 0 on that cycle.
- Write `addr=0x0FC0`, `len=128` -> with the macro, MWr `0x0FC0`/16 DW then `0x1000`/16 DW; without it, a single MWr `0x0FC0`/32 DW.
- Simultaneous starts, write `0x0000`/256 and read `0x2000`/1024, MRRS 512 -> grant order MWr `0x0000`, MRd `0x2000`/128 DW, MWr `0x0080`, MRd `0x2200`/128 DW; both done pulses fire.
- Write `len=3` (truncates to 0) -> no `tlp_req_valid`, `dma_wr_done` at N+1, busy never set.
- Read `0x4000`/64 with `tlp_req_ready` held low 5 cycles, plus a second `dma_rd_start` (`0x8000`) during the stall -> MRd `0x4000`/16 DW held stable until accepted; the second start is ignored; exactly one MRd is issued.
- `pcie_rst` pulsed while `tlp_req_valid` = 1 mid-job -> all outputs 0 the next cycle, no done pulse; a fresh start afterwards runs normally.

Source files
------------

// File: rtl/dma_req_sched.sv
`default_nettype none
// ============================================================================
// Module   : dma_req_sched
// Brief    : Latches one DMA-write and one DMA-read job and splits each into
//            MPS/MRRS-sized chunks. The two channels share one valid/ready
//            request port through a round-robin arbiter. Defining
//            DMA_SCHED_4K_SPLIT_EN keeps chunks from crossing 4 KB boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module dma_req_sched #(
  parameter int MAX_PAYLOAD_BYTES = 128,
  parameter int MAX_READ_BYTES    = 512
) (
  input  logic        pcie_clk,
  input  logic        pcie_rst,
  input  logic        dma_wr_start,
  input  logic [31:0] dma_wr_addr,
  input  logic [31:0] dma_wr_len,
  input  logic        dma_rd_start,
  input  logic [31:0] dma_rd_addr,
  input  logic [31:0] dma_rd_len,
  output logic        tlp_req_valid,
  input  logic        tlp_req_ready,
  output logic        tlp_req_type,
  output logic [31:0] tlp_req_addr,
  output logic [10:0] tlp_req_dw,
  output logic        dma_wr_busy,
  output logic        dma_rd_busy,
  output logic        dma_wr_done,
  output logic        dma_rd_done
);

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Index 0 is the write channel, index 1 the read channel (matches tlp_req_type).
  localparam logic [1:0][12:0] MAX_BYTES = {13'(MAX_READ_BYTES), 13'(MAX_PAYLOAD_BYTES)};

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       busy_q, busy_d;
  logic [1:0]       done_q, done_d;
  logic [1:0][31:0] cur_addr_q, cur_addr_d;
  logic [1:0][31:0] remaining_q, remaining_d;
  logic             req_valid_q, req_valid_d;
  logic             req_type_q, req_type_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [10:0]      req_dw_q, req_dw_d;

  logic [1:0]       start;
  logic [1:0][31:0] start_addr;
  logic [1:0][31:0] start_len;
  logic [1:0][31:0] trunc_len;
  logic [1:0][12:0] chunk_bytes;
  logic [1:0]       eligible;
  logic             grant;
  logic [31:0]      acc_bytes;
`ifdef DMA_SCHED_4K_SPLIT_EN
  logic [1:0][12:0] room_bytes;
`endif

  assign start      = {dma_rd_start, dma_wr_start};
  assign start_addr = {dma_rd_addr, dma_wr_addr};
  assign start_len  = {dma_rd_len, dma_wr_len};

  always_comb begin
    chunk_bytes = '0;
    eligible    = '0;
    trunc_len   = '0;
`ifdef DMA_SCHED_4K_SPLIT_EN
    room_bytes  = '0;
`endif
    for (int c = 0; c < 2; c++) begin
      trunc_len[c]   = start_len[c] & ~32'h3;
      eligible[c]    = busy_q[c] && (remaining_q[c] != 32'd0);
      chunk_bytes[c] = (remaining_q[c] < {19'd0, MAX_BYTES[c]}) ? remaining_q[c][12:0]
                                                                : MAX_BYTES[c];
`ifdef DMA_SCHED_4K_SPLIT_EN
      // Bytes left before the next 4 KB host page; 4096 when page-aligned.
      room_bytes[c] = 13'd4096 - {1'b0, cur_addr_q[c][11:0]};
      if (room_bytes[c] < chunk_bytes[c]) begin
        chunk_bytes[c] = room_bytes[c];
      end
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    done_d       = '0;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    req_valid_d  = req_valid_q;
    req_type_d   = req_type_q;
    req_addr_d   = req_addr_q;
    req_dw_d     = req_dw_q;
    grant        = (&eligible) ? ~last_grant_q : eligible[1];
    acc_bytes    = {19'd0, req_dw_q, 2'b00};

    case (state_q)
      ARB: begin
        if (|eligible) begin
          last_grant_d = grant;
          req_valid_d  = 1'b1;
          req_type_d   = grant;
          req_addr_d   = cur_addr_q[grant];
          req_dw_d     = chunk_bytes[grant][12:2];
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (tlp_req_ready) begin
          cur_addr_d[req_type_q]  = cur_addr_q[req_type_q] + acc_bytes;
          remaining_d[req_type_q] = remaining_q[req_type_q] - acc_bytes;
          if (remaining_q[req_type_q] == acc_bytes) begin
            busy_d[req_type_q] = 1'b0;
            done_d[req_type_q] = 1'b1;
          end
          req_valid_d = 1'b0;
          state_d     = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    // Start uses the busy value of this cycle, so a start coinciding with the
    // final handshake is dropped.
    for (int c = 0; c < 2; c++) begin
      if (start[c] && !busy_q[c]) begin
        cur_addr_d[c]  = start_addr[c] & ~32'h3;
        remaining_d[c] = trunc_len[c];
        if (trunc_len[c] == 32'd0) begin
          done_d[c] = 1'b1;
        end else begin
          busy_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      busy_q       <= '0;
      done_q       <= '0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      req_valid_q  <= 1'b0;
      req_type_q   <= 1'b0;
      req_addr_q   <= '0;
      req_dw_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      req_valid_q  <= req_valid_d;
      req_type_q   <= req_type_d;
      req_addr_q   <= req_addr_d;
      req_dw_q     <= req_dw_d;
    end
  end

  assign tlp_req_valid = req_valid_q;
  assign tlp_req_type  = req_type_q;
  assign tlp_req_addr  = req_addr_q;
  assign tlp_req_dw    = req_dw_q;
  assign dma_wr_busy   = busy_q[0];
  assign dma_rd_busy   = busy_q[1];
  assign dma_wr_done   = done_q[0];
  assign dma_rd_done   = done_q[1];

endmodule
`default_nettype wire

// File: tb/tb_dma_req_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_req_sched
// Brief    : Self-checking bench for dma_req_sched: job-level reference model,
//            per-cycle output compare, directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_req_sched;

  localparam int MPS  = 128;
  localparam int MRRS = 512;

  logic        pcie_clk = 1'b0;
  logic        pcie_rst = 1'b1;
  logic        dma_wr_start = 1'b0;
  logic [31:0] dma_wr_addr  = '0;
  logic [31:0] dma_wr_len   = '0;
  logic        dma_rd_start = 1'b0;
  logic [31:0] dma_rd_addr  = '0;
  logic [31:0] dma_rd_len   = '0;
  logic        tlp_req_ready = 1'b0;
  logic        tlp_req_valid;
  logic        tlp_req_type;
  logic [31:0] tlp_req_addr;
  logic [10:0] tlp_req_dw;
  logic        dma_wr_busy, dma_rd_busy, dma_wr_done, dma_rd_done;

  dma_req_sched #(.MAX_PAYLOAD_BYTES(MPS), .MAX_READ_BYTES(MRRS)) dut (
    .pcie_clk(pcie_clk), .pcie_rst(pcie_rst),
    .dma_wr_start(dma_wr_start), .dma_wr_addr(dma_wr_addr), .dma_wr_len(dma_wr_len),
    .dma_rd_start(dma_rd_start), .dma_rd_addr(dma_rd_addr), .dma_rd_len(dma_rd_len),
    .tlp_req_valid(tlp_req_valid), .tlp_req_ready(tlp_req_ready),
    .tlp_req_type(tlp_req_type), .tlp_req_addr(tlp_req_addr), .tlp_req_dw(tlp_req_dw),
    .dma_wr_busy(dma_wr_busy), .dma_rd_busy(dma_rd_busy),
    .dma_wr_done(dma_wr_done), .dma_rd_done(dma_rd_done)
  );

  always #5 pcie_clk = ~pcie_clk;

  int n_pass = 0;
  int n_total = 0;
  int n_printed = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model (job level) ----------------
  bit          m_busy [2];
  bit          m_done [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_rem  [2];
  bit          m_valid;
  bit          m_type;
  logic [31:0] m_oaddr;
  int unsigned m_odw;
  int          m_last = 1;
  bit          pre_busy [2];

  function automatic int unsigned model_chunk(int ch);
    int unsigned lim, c;
    lim = (ch == 0) ? MPS : MRRS;
    c   = (m_rem[ch] < lim) ? m_rem[ch] : lim;
`ifdef DMA_SCHED_4K_SPLIT_EN
    begin
      int unsigned room;
      room = 4096 - (m_addr[ch] % 4096);
      if (room < c) c = room;
    end
`endif
    return c;
  endfunction

  task automatic model_start(int ch, logic [31:0] a, logic [31:0] l);
    logic [31:0] tl;
    tl = l & ~32'h3;
    if (pre_busy[ch]) return;
    if (tl == 0) begin
      m_done[ch] = 1'b1;
    end else begin
      m_busy[ch] = 1'b1;
      m_addr[ch] = a & ~32'h3;
      m_rem[ch]  = tl;
    end
  endtask

  always @(posedge pcie_clk) begin
    if (pcie_rst) begin
      for (int c = 0; c < 2; c++) begin
        m_busy[c] = 0; m_done[c] = 0; m_addr[c] = 0; m_rem[c] = 0;
      end
      m_valid = 0; m_type = 0; m_oaddr = 0; m_odw = 0; m_last = 1;
    end else begin
      pre_busy = m_busy;
      m_done[0] = 0;
      m_done[1] = 0;
      if (m_valid) begin
        if (tlp_req_ready) begin
          int ch;
          ch = int'(m_type);
          m_addr[ch] = m_addr[ch] + m_odw * 4;
          m_rem[ch]  = m_rem[ch] - m_odw * 4;
          if (m_rem[ch] == 0) begin
            m_busy[ch] = 0;
            m_done[ch] = 1;
          end
          m_valid = 0;
        end
      end else begin
        bit e0, e1;
        int g;
        e0 = m_busy[0] && m_rem[0] != 0;
        e1 = m_busy[1] && m_rem[1] != 0;
        if (e0 || e1) begin
          g       = (e0 && e1) ? 1 - m_last : (e1 ? 1 : 0);
          m_last  = g;
          m_valid = 1;
          m_type  = (g == 1);
          m_oaddr = m_addr[g];
          m_odw   = model_chunk(g) / 4;
        end
      end
      if (dma_wr_start) model_start(0, dma_wr_addr, dma_wr_len);
      if (dma_rd_start) model_start(1, dma_rd_addr, dma_rd_len);
    end
  end

  // ---------------- per-cycle compare + accepted-request log ----------------
  bit          log_t [$];
  logic [31:0] log_a [$];
  int          log_d [$];
  int          wr_done_cnt = 0;
  int          rd_done_cnt = 0;

  always @(negedge pcie_clk) begin
    if (chk_en) begin
      bit ok;
      ok = (tlp_req_valid === m_valid) && (dma_wr_busy === m_busy[0]) &&
           (dma_rd_busy === m_busy[1]) && (dma_wr_done === m_done[0]) &&
           (dma_rd_done === m_done[1]);
      if (m_valid)
        ok = ok && (tlp_req_type === m_type) && (tlp_req_addr === m_oaddr) &&
             (tlp_req_dw === 11'(m_odw));
      n_total++;
      if (ok) n_pass++;
      else if (n_printed < 40) begin
        n_printed++;
        $display("FAIL cycle_model t=%0t got v=%0b ty=%0b a=%08h dw=%0d wb=%0b rb=%0b wd=%0b rd=%0b exp v=%0b ty=%0b a=%08h dw=%0d wb=%0b rb=%0b wd=%0b rd=%0b",
                 $time, tlp_req_valid, tlp_req_type, tlp_req_addr, tlp_req_dw,
                 dma_wr_busy, dma_rd_busy, dma_wr_done, dma_rd_done,
                 m_valid, m_type, m_oaddr, m_odw, m_busy[0], m_busy[1], m_done[0], m_done[1]);
      end
      if (tlp_req_valid && tlp_req_ready && !pcie_rst) begin
        log_t.push_back(tlp_req_type);
        log_a.push_back(tlp_req_addr);
        log_d.push_back(int'(tlp_req_dw));
      end
      if (dma_wr_done) wr_done_cnt++;
      if (dma_rd_done) rd_done_cnt++;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_log(string name, int idx, bit t, logic [31:0] a, int dw);
    n_total++;
    if (idx < log_t.size() && log_t[idx] == t && log_a[idx] == a && log_d[idx] == dw)
      n_pass++;
    else if (idx < log_t.size())
      $display("FAIL %s got ty=%0b a=%08h dw=%0d expected ty=%0b a=%08h dw=%0d",
               name, log_t[idx], log_a[idx], log_d[idx], t, a, dw);
    else
      $display("FAIL %s got no request (log size %0d) expected ty=%0b a=%08h dw=%0d",
               name, log_t.size(), t, a, dw);
  endtask

  task automatic tick();
    @(posedge pcie_clk);
    #2;
  endtask

  task automatic clear_log();
    log_t.delete(); log_a.delete(); log_d.delete();
    wr_done_cnt = 0; rd_done_cnt = 0;
  endtask

  task automatic do_reset();
    pcie_rst = 1'b1;
    tick();
    tick();
    pcie_rst = 1'b0;
    clear_log();
  endtask

  task automatic start_wr(logic [31:0] a, logic [31:0] l);
    dma_wr_start = 1'b1; dma_wr_addr = a; dma_wr_len = l;
    tick();
    dma_wr_start = 1'b0;
  endtask

  task automatic start_rd(logic [31:0] a, logic [31:0] l);
    dma_rd_start = 1'b1; dma_rd_addr = a; dma_rd_len = l;
    tick();
    dma_rd_start = 1'b0;
  endtask

  task automatic wait_idle(string name, int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!dma_wr_busy && !dma_rd_busy && !tlp_req_valid) break;
      tick();
    end
    if (i >= budget) begin
      n_total++;
      $display("FAIL %s timeout got busy after %0d cycles expected idle", name, budget);
    end
    tick();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    chk_en = 1'b1;
    @(negedge pcie_clk);
    chk("reset_valid", 32'(tlp_req_valid), 0);
    chk("reset_busy", {30'd0, dma_rd_busy, dma_wr_busy}, 0);
    chk("reset_done", {30'd0, dma_rd_done, dma_wr_done}, 0);
    #2;

    // Two full-size MWr chunks with 2-cycle start latency
    tlp_req_ready = 1'b1;
    start_wr(32'h1000, 256);
    @(negedge pcie_clk);
    chk("lat_busy_n1", 32'(dma_wr_busy), 1);
    chk("lat_valid_n1", 32'(tlp_req_valid), 0);
    @(negedge pcie_clk);
    chk("lat_valid_n2", 32'(tlp_req_valid), 1);
    #2;
    wait_idle("t1_idle", 100);
    chk_log("t1_req0", 0, 0, 32'h1000, 32);
    chk_log("t1_req1", 1, 0, 32'h1080, 32);
    chk("t1_count", log_t.size(), 2);
    chk("t1_done_cnt", wr_done_cnt, 1);

    // 4 KB boundary crossing
    do_reset();
    start_wr(32'h0FC0, 128);
    wait_idle("t2_idle", 100);
`ifdef DMA_SCHED_4K_SPLIT_EN
    chk_log("t2_req0", 0, 0, 32'h0FC0, 16);
    chk_log("t2_req1", 1, 0, 32'h1000, 16);
    chk("t2_count", log_t.size(), 2);
`else
    chk_log("t2_req0", 0, 0, 32'h0FC0, 32);
    chk("t2_count", log_t.size(), 1);
`endif

    // Simultaneous starts: round-robin, write wins the first tie
    do_reset();
    dma_wr_start = 1'b1; dma_wr_addr = 32'h0000; dma_wr_len = 256;
    dma_rd_start = 1'b1; dma_rd_addr = 32'h2000; dma_rd_len = 1024;
    tick();
    dma_wr_start = 1'b0; dma_rd_start = 1'b0;
    wait_idle("t3_idle", 100);
    chk_log("t3_req0", 0, 0, 32'h0000, 32);
    chk_log("t3_req1", 1, 1, 32'h2000, 128);
    chk_log("t3_req2", 2, 0, 32'h0080, 32);
    chk_log("t3_req3", 3, 1, 32'h2200, 128);
    chk("t3_count", log_t.size(), 4);
    chk("t3_wr_done", wr_done_cnt, 1);
    chk("t3_rd_done", rd_done_cnt, 1);

    // Length truncating to zero
    do_reset();
    start_wr(32'h5000, 3);
    @(negedge pcie_clk);
    chk("t4_done_n1", 32'(dma_wr_done), 1);
    chk("t4_busy_n1", 32'(dma_wr_busy), 0);
    @(negedge pcie_clk);
    chk("t4_done_n2", 32'(dma_wr_done), 0);
    #2;
    tick(); tick();
    chk("t4_count", log_t.size(), 0);

    // Backpressure stall plus ignored second start
    do_reset();
    tlp_req_ready = 1'b0;
    start_rd(32'h4000, 64);
    tick();
    start_rd(32'h8000, 64);
    tick(); tick(); tick();
    chk("t5_hold_valid", 32'(tlp_req_valid), 1);
    chk("t5_hold_addr", tlp_req_addr, 32'h4000);
    chk("t5_hold_dw", 32'(tlp_req_dw), 16);
    tlp_req_ready = 1'b1;
    wait_idle("t5_idle", 100);
    chk_log("t5_req0", 0, 1, 32'h4000, 16);
    chk("t5_count", log_t.size(), 1);
    chk("t5_rd_done", rd_done_cnt, 1);

    // Reset mid-job while a request is pending
    do_reset();
    tlp_req_ready = 1'b0;
    start_wr(32'h1000, 256);
    tick(); tick();
    chk("t6_pre_valid", 32'(tlp_req_valid), 1);
    pcie_rst = 1'b1;
    tick();
    pcie_rst = 1'b0;
    chk("t6_rst_valid", 32'(tlp_req_valid), 0);
    chk("t6_rst_busy", 32'(dma_wr_busy), 0);
    chk("t6_rst_done", 32'(dma_wr_done), 0);
    clear_log();
    tlp_req_ready = 1'b1;
    start_wr(32'h3000, 8);
    wait_idle("t6_idle", 100);
    chk_log("t6_req0", 0, 0, 32'h3000, 2);
    chk("t6_done_cnt", wr_done_cnt, 1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      tlp_req_ready = ($urandom_range(0, 3) != 0);
      dma_wr_start  = ($urandom_range(0, 15) == 0);
      dma_wr_addr   = 32'h1000_0000 + $urandom_range(0, 32'h3FFF);
      dma_wr_len    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 1500);
      dma_rd_start  = ($urandom_range(0, 15) == 0);
      dma_rd_addr   = 32'h2000_0000 + $urandom_range(0, 32'h3FFF);
      dma_rd_len    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 3000);
      pcie_rst      = ($urandom_range(0, 499) == 0);
      tick();
    end
    dma_wr_start = 1'b0; dma_rd_start = 1'b0; pcie_rst = 1'b0;
    tlp_req_ready = 1'b1;
    wait_idle("rand_drain", 5000);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
